// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester handshake and serial-line bundle for uart_tx_scheduler
interface uart_tx_scheduler_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx;
    logic       busy;
    logic       last_grant;
    logic       frame_done;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1, tx, busy, last_grant, frame_done
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1, tx, busy, last_grant, frame_done
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin two-requester 8N1 UART transmitter timed by a 16x brclk
module uart_tx_scheduler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               brclk,
    uart_tx_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic                   last_grant_q, last_grant_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sync1_q, sync2_q, hist_q;
    logic                   tick;

    assign tick = sync2_q & ~hist_q;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            last_grant_q <= 1'b1;
            frame_done_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            last_grant_q <= last_grant_d;
            frame_done_q <= frame_done_d;
            sync1_q      <= brclk;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        last_grant_d = last_grant_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // On contention the requester that did not win last time goes first.
                if (bus.req0 && (!bus.req1 || last_grant_q)) begin
                    state_d      = START;
                    tx_d         = 1'b0;
                    tick_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    shift_d      = bus.data0[DATA_BITS-1:0];
                    ack0_d       = 1'b1;
                    last_grant_d = 1'b0;
                end else if (bus.req1) begin
                    state_d      = START;
                    tx_d         = 1'b0;
                    tick_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    shift_d      = bus.data1[DATA_BITS-1:0];
                    ack1_d       = 1'b1;
                    last_grant_d = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d    = DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        tx_d       = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            // tx is registered, so present the next bit while shifting.
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            tx_d      = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d      = IDLE;
                        tick_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.last_grant = last_grant_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
    logic sysclk;
    logic reset;
    logic brclk;
    bit   br_en = 1'b1;
    int   br_cnt;
    int   n_assert = 0;
    int   n_fail   = 0;

    uart_tx_scheduler_if u ();

    uart_tx_scheduler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .brclk  (brclk),
        .bus    (u.slave)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // brclk toggles every 2 sysclk cycles while enabled, so one tick per 4 cycles.
    initial begin
        brclk  = 1'b0;
        br_cnt = 0;
        forever begin
            @(posedge sysclk);
            #2;
            if (br_en) begin
                br_cnt++;
                if (br_cnt == 2) begin
                    br_cnt = 0;
                    brclk  = ~brclk;
                end
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows one frame from its grant to frame_done, sampling tx mid-bit (64 cycles per bit).
    task automatic frame(input string tag, input logic [7:0] exp_b, input logic idx,
                         input bit drop, input logic [7:0] nd, input int freeze_at,
                         input int exp_wait);
        int         w, c, off, busy_n, fd_in_busy, frz_bad;
        logic [9:0] bits;
        logic       frz_tx;
        bits = {1'b1, exp_b, 1'b0};
        w = 0;
        do begin
            step();
            w++;
        end while (!u.busy && w < 2000);
        if (!u.busy) begin
            chk({tag, "_start_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_wait"}, w, exp_wait);
        chk({tag, "_ack0"}, u.ack0, (idx == 1'b0));
        chk({tag, "_ack1"}, u.ack1, (idx == 1'b1));
        chk({tag, "_start_tx"}, u.tx, 0);
        chk({tag, "_last_grant"}, u.last_grant, idx);
        c = 0; off = 0; busy_n = 0; fd_in_busy = 0;
        while (u.busy && c < 4000) begin
            busy_n++;
            if (u.frame_done) fd_in_busy++;
            if (c == 1) begin
                chk({tag, "_ack_pulse"}, {u.ack0, u.ack1}, 0);
                if (idx == 1'b0) begin
                    if (drop) u.req0 = 1'b0; else u.data0 = nd;
                end else begin
                    if (drop) u.req1 = 1'b0; else u.data1 = nd;
                end
            end
            for (int k = 0; k < 10; k++)
                if (c == 32 + 64 * k + off)
                    chk($sformatf("%s_bit%0d", tag, k), u.tx, bits[k]);
            if (c == freeze_at) begin
                br_en   = 1'b0;
                frz_tx  = u.tx;
                frz_bad = 0;
                repeat (1000) begin
                    step();
                    if (u.tx !== frz_tx || u.busy !== 1'b1 || u.frame_done !== 1'b0) frz_bad++;
                end
                br_en = 1'b1;
                chk({tag, "_frozen"}, frz_bad, 0);
                off    = 1000;
                c      += 1000;
                busy_n += 1000;
            end
            step();
            c++;
        end
        chk({tag, "_end_timeout"}, u.busy, 0);
        chk({tag, "_frame_done"}, u.frame_done, 1);
        chk({tag, "_fd_in_busy"}, fd_in_busy, 0);
        chk({tag, "_busy_len"}, (busy_n >= 637 + off && busy_n <= 640 + off), 1);
    endtask

    initial begin
        int         bad;
        int         w;
        u.req0  = 1'b0;
        u.req1  = 1'b0;
        u.data0 = 8'h00;
        u.data1 = 8'h00;
        reset   = 1'b0;
        repeat (4) step();
        reset = 1'b1;

        // 1: reset state and idle
        chk("rst_tx", u.tx, 1);
        chk("rst_busy", u.busy, 0);
        chk("rst_ack", {u.ack0, u.ack1}, 0);
        chk("rst_last_grant", u.last_grant, 1);
        chk("rst_frame_done", u.frame_done, 0);
        bad = 0;
        repeat (200) begin
            step();
            if (u.tx !== 1'b1 || u.busy !== 1'b0 || u.ack0 !== 1'b0 || u.ack1 !== 1'b0 ||
                u.last_grant !== 1'b1 || u.frame_done !== 1'b0) bad++;
        end
        chk("idle_200", bad, 0);

        // 2: single 0xA5 frame from requester 0
        u.req0  = 1'b1;
        u.data0 = 8'hA5;
        frame("a5", 8'hA5, 1'b0, 1'b1, 8'h00, -1, 1);

        // 3: simultaneous requests from a fresh reset: 0 first, then 1 with one idle cycle
        reset = 1'b0;
        step();
        reset = 1'b1;
        u.req0  = 1'b1; u.data0 = 8'h55;
        u.req1  = 1'b1; u.data1 = 8'h0F;
        frame("both_55", 8'h55, 1'b0, 1'b1, 8'h00, -1, 1);
        frame("both_0f", 8'h0F, 1'b1, 1'b1, 8'h00, -1, 1);

        // 4: both held, data changes after each ack, grants alternate
        u.req0 = 1'b1; u.data0 = 8'h11;
        u.req1 = 1'b1; u.data1 = 8'h22;
        frame("rr_a", 8'h11, 1'b0, 1'b0, 8'h33, -1, 1);
        frame("rr_b", 8'h22, 1'b1, 1'b0, 8'h44, -1, 1);
        frame("rr_c", 8'h33, 1'b0, 1'b1, 8'h00, -1, 1);
        frame("rr_d", 8'h44, 1'b1, 1'b1, 8'h00, -1, 1);

        // 5: reset during data bit 3 of a 0x00 frame
        u.req0 = 1'b1; u.data0 = 8'h00;
        w = 0;
        do begin
            step();
            w++;
        end while (!u.busy && w < 2000);
        chk("abort_wait", w, 1);
        repeat (288) step();
        chk("abort_pre_tx", u.tx, 0);
        chk("abort_pre_busy", u.busy, 1);
        reset  = 1'b0;
        u.req0 = 1'b0;
        step();
        chk("abort_tx", u.tx, 1);
        chk("abort_busy", u.busy, 0);
        chk("abort_ack_fd", {u.ack0, u.ack1, u.frame_done}, 0);
        chk("abort_last_grant", u.last_grant, 1);
        repeat (3) step();
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (u.ack0 !== 1'b0 || u.ack1 !== 1'b0 || u.frame_done !== 1'b0 ||
                u.busy !== 1'b0 || u.tx !== 1'b1) bad++;
        end
        chk("abort_quiet", bad, 0);
        u.req1 = 1'b1; u.data1 = 8'h3C;
        frame("after_abort", 8'h3C, 1'b1, 1'b1, 8'h00, -1, 1);

        // 6: brclk frozen for 1000 cycles mid data bit 2
        u.req0 = 1'b1; u.data0 = 8'h96;
        frame("freeze", 8'h96, 1'b0, 1'b1, 8'h00, 224, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between two byte requesters (CPU peripheral port and debug port) using round-robin arbitration, and serialises each granted byte as an 8N1 frame. Bit timing comes from the 16x-oversample brclk produced by the baud-rate generator; brclk is sampled in the sysclk domain and converted to a single-cycle tick. The block sits between the peripheral bus and the UART pin.

Parameters:
OVERSAMPLE, 16, ticks per bit (valid range 2..16)
DATA_BITS, 8, data bits per frame, LSB first (valid range 5..8)

Ports:
sysclk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset, sampled on the sysclk rising edge
brclk  input  1  16x baud clock from the generator (slow square wave, treated as data)
req0  input  1  requester 0 has a byte pending; held until ack0
data0  input  8  requester 0 byte; stable while req0 is high
ack0  output  1  one-cycle pulse: data0 captured
req1  input  1  requester 1 has a byte pending; held until ack1
data1  input  8  requester 1 byte; stable while req1 is high
ack1  output  1  one-cycle pulse: data1 captured
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (any state except IDLE)
last_grant  output  1  index of the most recently granted requester
frame_done  output  1  one-cycle pulse at the end of a stop bit

Behaviour:
- Reset (reset==0 at a sysclk edge): state=IDLE; tx=1; ack0=ack1=0; busy=0; last_grant=1, so requester 0 wins first; frame_done=0; counters and shift register cleared; brclk sync flops cleared.
- A reset mid-frame aborts the frame. tx returns high on that edge and no ack or frame_done is issued for the aborted frame.
- Tick generation:
  - brclk passes through a 2-flop synchroniser plus a history flop.
  - tick = sync2 & ~hist, i.e. one sysclk cycle per brclk rising edge.
  - tick is generated in every state but consumed only outside IDLE.
- Arbitration (IDLE only), evaluated every cycle:
  - Only req0: grant 0.
  - Only req1: grant 1.
  - Both: grant the requester that is not last_grant.
  - On a grant in cycle N:
    - ackX=1 for cycle N+1 only.
    - The shift register loads dataX.
    - last_grant is updated.
    - The state becomes START with tx=0 and bit_cnt=0, tick_cnt=0 from edge N+1.
  - A request withdrawn before grant has no effect.
  - After its ack, a requester must deassert or present new data. A req held high is treated as a new byte at the next arbitration.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0. Each tick increments tick_cnt. When tick_cnt reaches OVERSAMPLE-1 and a tick occurs: go to DATA, tick_cnt=0, bit_cnt=0.
  - DATA: tx=shift[0]. After OVERSAMPLE ticks: shift right by 1 and bit_cnt+1. After bit DATA_BITS-1 completes, go to STOP.
  - STOP: tx=1. After OVERSAMPLE ticks: frame_done=1 for one cycle, state=IDLE.
- Arbitration resumes the cycle after STOP exits, so back-to-back frames have no idle gap beyond that single sysclk cycle.
- Frame length: exactly (DATA_BITS+2)*OVERSAMPLE ticks from START entry.
- A frame's first bit period can be up to one tick period shorter, because the tick phase is free-running. This is accepted (< 1/16 bit).
- Widths: tick_cnt is 4 bits and bit_cnt is 3 bits; both wrap only through explicit reload, never overflow.
- Simultaneous events: a new req arriving during a frame waits. A tick landing on the grant cycle is ignored (the state is still IDLE).
- The tx output is registered (no glitches).

Test Plan:
1. Reset, then idle with a bench brclk toggling every 2 sysclk -> tx=1, busy=0, ack0=ack1=0, last_grant=1, for 200 cycles.
2. req0=1, data0=0xA5 -> ack0 pulses 1 cycle after req0 is sampled. tx shows 0, then 1,0,1,0,0,1,0,1, then 1. Each bit is 16 ticks. busy spans 160 ticks. frame_done pulses once.
3. req0 and req1 asserted in the same cycle (data0=0x55, data1=0x0F) -> 0x55 sent first (ack0), then 0x0F (ack1). Exactly one sysclk gap between frame_done and the second START.
4. req0 and req1 held continuously with changing data -> grants alternate 0,1,0,1 across 4 frames, and last_grant toggles each grant.
5. reset asserted during the 4th data bit of a 0x00 frame -> tx=1 on that edge, no ack or frame_done. After release, a new req1 frame transmits correctly.
6. brclk held constant for 1000 cycles mid-frame -> tx and state frozen. Frame resumes on the next brclk rise with correct remaining bit count.
